// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected tile controller.
//   fc_state_e : sequencer states
//   FC_*       : default parameter values used by fc_tile_ctrl / fc_addr_gen
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } fc_state_e;

  localparam int FC_NODE_W   = 7;
  localparam int FC_LANES    = 4;
  localparam int FC_WADDR_W  = 14;
  localparam int FC_PIPE_LAT = 2;

endpackage

// File: rtl/fc_addr_gen.sv
// Read address generator for one FC job.
//   ld_i        : new job, clear read index and weight base
//   inc_i       : advance read index by one
//   next_pass_i : step weight base by in_num_i, restart read index
//   in_num_i    : latched input node count (nonzero while a job runs)
//   i_o         : current read index (ifmap address)
//   wbase_o     : weight address of the current pass's first word
//   last_rd_o   : read index is at the final input node
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int NODE_W  = FC_NODE_W,
  parameter int WADDR_W = FC_WADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_i,
  input  logic               inc_i,
  input  logic               next_pass_i,
  input  logic [NODE_W-1:0]  in_num_i,
  output logic [NODE_W-1:0]  i_o,
  output logic [WADDR_W-1:0] wbase_o,
  output logic               last_rd_o
);

  logic [NODE_W-1:0]  i_q, i_d;
  logic [WADDR_W-1:0] wbase_q, wbase_d;

  // Weight base accumulates the input count each pass so the weight
  // address needs no multiplier.
  always_comb begin
    i_d     = i_q;
    wbase_d = wbase_q;
    if (ld_i) begin
      i_d     = '0;
      wbase_d = '0;
    end else if (next_pass_i) begin
      i_d     = '0;
      wbase_d = wbase_q + WADDR_W'(in_num_i);
    end else if (inc_i) begin
      i_d     = i_q + NODE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      wbase_q <= '0;
    end else begin
      i_q     <= i_d;
      wbase_q <= wbase_d;
    end
  end

  assign i_o       = i_q;
  assign wbase_o   = wbase_q;
  assign last_rd_o = (i_q == in_num_i - NODE_W'(1));

endmodule

// File: rtl/fc_tile_ctrl.sv
// Fully-connected layer sequencer. Splits out_node_num outputs into
// ceil(out/LANES) passes; each pass clears the accumulators, streams
// in_node_num ifmap/weight reads, waits out the MAC pipeline and then
// flags the results with a lane mask and output base index.
//   start_i / busy_o / done_o       : job handshake
//   in_node_num_i / out_node_num_i  : job sizes, sampled on accepted start
//   ifmap_rden_o / ifmap_rdptr_o    : ifmap buffer read port
//   wbuf_rden_o / wbuf_rdptr_o      : weight buffer read port
//   rst_buf_n_o                     : active-low accumulator clear
//   valid_o / lane_mask_o / out_base_o / last_o : pass result flags
// Every output is decoded from registers only.
module fc_tile_ctrl
  import fc_pkg::*;
#(
  parameter int NODE_W   = FC_NODE_W,
  parameter int LANES    = FC_LANES,
  parameter int WADDR_W  = FC_WADDR_W,
  parameter int PIPE_LAT = FC_PIPE_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [NODE_W-1:0]  in_node_num_i,
  input  logic [NODE_W-1:0]  out_node_num_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ifmap_rden_o,
  output logic [NODE_W-1:0]  ifmap_rdptr_o,
  output logic               wbuf_rden_o,
  output logic [WADDR_W-1:0] wbuf_rdptr_o,
  output logic               rst_buf_n_o,
  output logic               valid_o,
  output logic [LANES-1:0]   lane_mask_o,
  output logic [NODE_W-1:0]  out_base_o,
  output logic               last_o
);

  localparam int DRW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  fc_state_e          state_q, state_d;
  logic [DRW-1:0]     drain_q, drain_d;
  logic [NODE_W-1:0]  in_q, in_d;
  logic [NODE_W-1:0]  out_q, out_d;
  logic [NODE_W:0]    base_q, base_d;   // extra bit: base may pass 2^NODE_W-1
  logic               done_q, done_d;

  logic               ld, inc, next_pass, last_rd;
  logic [NODE_W-1:0]  rd_i;
  logic [WADDR_W-1:0] wbase;
  logic               drain_end, last_c;
  logic [LANES-1:0]   mask_c;

  fc_addr_gen #(.NODE_W(NODE_W), .WADDR_W(WADDR_W)) u_addr (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_i        (ld),
    .inc_i       (inc),
    .next_pass_i (next_pass),
    .in_num_i    (in_q),
    .i_o         (rd_i),
    .wbase_o     (wbase),
    .last_rd_o   (last_rd)
  );

  assign drain_end = (state_q == DRAIN) && (drain_q == DRW'(PIPE_LAT));

  // Lane l carries a real output when base+l < out; compared one bit wider
  // than base so nothing wraps.
  always_comb begin
    mask_c = '0;
    for (int l = 0; l < LANES; l++)
      mask_c[l] = ({1'b0, base_q} + (NODE_W+2)'(l)) < {2'b0, out_q};
  end
  assign last_c = ({1'b0, base_q} + (NODE_W+2)'(LANES)) >= {2'b0, out_q};

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    in_d      = in_q;
    out_d     = out_q;
    base_d    = base_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    inc       = 1'b0;
    next_pass = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((in_node_num_i != '0) && (out_node_num_i != '0)) begin
            in_d    = in_node_num_i;
            out_d   = out_node_num_i;
            base_d  = '0;
            ld      = 1'b1;
            state_d = CLEAR;
          end else begin
            done_d = 1'b1;   // empty job: immediate completion
          end
        end
      end
      CLEAR: state_d = READ;
      READ: begin
        if (last_rd) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          inc = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          if (last_c) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            base_d    = base_q + (NODE_W+1)'(LANES);
            next_pass = 1'b1;
            state_d   = CLEAR;
          end
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      in_q    <= '0;
      out_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      in_q    <= in_d;
      out_q   <= out_d;
      base_q  <= base_d;
      done_q  <= done_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign ifmap_rden_o  = (state_q == READ);
  assign wbuf_rden_o   = (state_q == READ);
  assign ifmap_rdptr_o = rd_i;
  assign wbuf_rdptr_o  = wbase + WADDR_W'(rd_i);
  assign rst_buf_n_o   = (state_q != CLEAR);
  assign valid_o       = drain_end;
  assign lane_mask_o   = drain_end ? mask_c : '0;
  assign out_base_o    = drain_end ? base_q[NODE_W-1:0] : '0;
  assign last_o        = drain_end & last_c;

endmodule
